// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM states
// and the compare-opcode classifier.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_ABS = 3'b110;
    localparam logic [2:0] OP_SEQ = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic is_cmp(input logic [2:0] op);
        return (op == OP_SLT) || (op == OP_SEQ);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin grant: search starts one past the last winner.
// Purely combinational; gating is done by the caller.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    last,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    // First asserted valid at or after last+1, wrapping around
    always_comb begin
        int   k;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (int'(last) + i) % NUM_REQ;
            if (!found && valid[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters with
// registered operands, tagged responses and the condition bit.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [3*NUM_REQ-1:0] req_opcode_i,
    input  logic [8*NUM_REQ-1:0] req_rs_i,
    input  logic [8*NUM_REQ-1:0] req_rt_i,
    output logic [2:0]           alu_opcode_o,
    output logic [7:0]           alu_rs_o,
    output logic [7:0]           alu_rt_o,
    input  logic [7:0]           alu_result_i,
    input  logic                 alu_zero_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic [7:0]           rsp_result_o,
    output logic                 cb_o
);

    logic [1:0]         state;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    id_q;
    logic               arb_en;
    logic               accept;
    logic [2:0]         sel_op;
    logic [7:0]         sel_rs;
    logic [7:0]         sel_rt;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_rr (
        .valid(req_valid_i),
        .last (last_grant),
        .grant(grant),
        .idx  (win_idx)
    );

    // Arbiter is live in IDLE and in RESP once the response drains
    assign arb_en = rst_n_i &&
                    ((state == ST_IDLE) ||
                     ((state == ST_RESP) && rsp_ready_i));
    assign req_ready_o = arb_en ? grant : '0;
    assign accept      = |req_ready_o;

    // Operand mux for the current winner
    always_comb begin
        int s;
        s      = int'(win_idx);
        sel_op = req_opcode_i[3*s +: 3];
        sel_rs = req_rs_i[8*s +: 8];
        sel_rt = req_rt_i[8*s +: 8];
    end

    // FSM, operand latch, result capture and condition bit
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_IDLE;
            alu_opcode_o <= 3'b000;
            alu_rs_o     <= 8'h00;
            alu_rt_o     <= 8'h00;
            id_q         <= '0;
            last_grant   <= ID_W'(NUM_REQ - 1);
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= '0;
            rsp_result_o <= 8'h00;
            cb_o         <= 1'b0;
        end else begin
            unique case (state)
                ST_EXEC: begin
                    if (is_cmp(alu_opcode_o)) begin
                        rsp_result_o <= 8'h00;
                        cb_o         <= alu_zero_i;
                    end else begin
                        rsp_result_o <= alu_result_i;
                    end
                    rsp_id_o    <= id_q;
                    rsp_valid_o <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= accept ? ST_EXEC : ST_IDLE;
                    end
                end
                default: begin
                    state <= accept ? ST_EXEC : ST_IDLE;
                end
            endcase
            if (accept) begin
                alu_opcode_o <= sel_op;
                alu_rs_o     <= sel_rs;
                alu_rt_o     <= sel_rt;
                id_q         <= win_idx;
                last_grant   <= win_idx;
            end
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational 8-bit ALU between `NUM_REQ` requesters (e.g. the execute stage and the branch-compare unit). It accepts one operation at a time via a valid/ready handshake, chosen round-robin. It registers the operands and drives the ALU from those registers, captures the result, and returns a tagged response. It owns the architectural condition bit (CB), which is updated only by compare opcodes.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `ID_W`, default 1: response id width, equal to `$clog2(NUM_REQ)`.
- `clk_i` input, 1 bit: single clock; all state updates on its rising edge.
- `rst_n_i` input, 1 bit: reset, asynchronous, active-low.
- `req_valid_i` input, `NUM_REQ` bits: per-requester request valid.
- `req_ready_o` output, `NUM_REQ` bits: per-requester accept, one-hot or zero.
- `req_opcode_i` input, `3*NUM_REQ` bits: opcodes; requester k occupies bits `[3k+2:3k]`.
- `req_rs_i` input, `8*NUM_REQ` bits: rs operands, packed the same way.
- `req_rt_i` input, `8*NUM_REQ` bits: rt operands, packed the same way.
- `alu_opcode_o` output, 3 bits: opcode to the ALU, registered.
- `alu_rs_o` output, 8 bits: rs to the ALU, registered.
- `alu_rt_o` output, 8 bits: rt to the ALU, registered.
- `alu_result_i` input, 8 bits: ALU result.
- `alu_zero_i` input, 1 bit: ALU compare flag.
- `rsp_valid_o` output, 1 bit: response valid.
- `rsp_ready_i` input, 1 bit: response consumer ready.
- `rsp_id_o` output, `ID_W` bits: index of the requester that owns the response.
- `rsp_result_o` output, 8 bits: captured result.
- `cb_o` output, 1 bit: condition bit.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - The round-robin arbiter picks a winner among the asserted `req_valid_i` bits.
  - `req_ready_o[winner]`=1 in the same cycle, combinationally.
  - On the accepting edge: latch opcode, rs, rt and id into the `alu_*_o` and id registers; set `last_grant` to the winner; go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (exactly 1 cycle): the ALU evaluates the registered inputs. On the edge leaving EXEC:
  - opcodes 000, 001, 010, 011, 100 and 110: `rsp_result_o` ← `alu_result_i`; CB unchanged.
  - opcodes 101 (slt) and 111 (seq): `rsp_result_o` ← 8'h00; `cb_o` ← `alu_zero_i`.
  - `rsp_valid_o` ← 1; go to RESP.
- RESP:
  - `rsp_valid_o`=1. `rsp_result_o`, `rsp_id_o` and `cb_o` hold stable until the handshake completes.
  - When `rsp_ready_i`=1: the response completes. The arbiter is also live in this cycle (`req_ready_o` is computed as in IDLE).
    - If some requester is valid, it is accepted and the FSM goes to EXEC.
    - Otherwise the FSM goes to IDLE.
  - When `rsp_ready_i`=0: `req_ready_o` is all zero.
- Round-robin priority: the search starts at `last_grant+1` (mod `NUM_REQ`). Reset sets `last_grant` to `NUM_REQ-1`, so requester 0 wins first.
- `req_ready_o` is zero in EXEC, in RESP without `rsp_ready_i`, and during reset.
- Requesters must hold valid, opcode and operands stable until ready. The block does not buffer a dropped request.
- Reset (asynchronous; any state, including mid-EXEC or RESP):
  - State ← IDLE.
  - All registered outputs ← 0.
  - `last_grant` ← `NUM_REQ-1`.
  - An in-flight operation is discarded and produces no response.

## Timing
- Reset values: `rsp_valid_o`=0, `rsp_result_o`=8'h00, `rsp_id_o`=0, `cb_o`=0, `alu_opcode_o`=3'b000, `alu_rs_o`=8'h00, `alu_rt_o`=8'h00.
- Latency: accept at edge N → `rsp_valid_o`=1 after edge N+1.
- Throughput: one operation per 2 cycles with `rsp_ready_i` held at 1 (accept in RESP → EXEC).
- `cb_o` changes only on the EXEC→RESP edge of a compare opcode.
- Combinational paths:
  - `req_valid_i`/`rsp_ready_i` → `req_ready_o`.
  - `alu_result_i`/`alu_zero_i` → register only.
  - No path from `alu_*_o` back to `req_ready_o`.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants: `OP_AND`=000, `OP_ADD`=001, `OP_SLL`=010, `OP_SRL`=011, `OP_SUB`=100, `OP_SLT`=101, `OP_ABS`=110, `OP_SEQ`=111.
  - FSM state encoding.
  - An `is_cmp` opcode function, true for 101 and 111.
- One sub-module `rr_arbiter`:
  - Combinational grant from the valid vector and `last_grant`.
  - Outputs a one-hot grant and a binary index.
- The FSM, operand/response registers and CB live in `alu_arbiter`.

## Test plan
- Reset: assert `rst_n_i`=0 mid-RESP → all outputs 0 immediately, no response. After release, a request from req1 alone is accepted first cycle with id=1.
- Single add:
  - req0 sends opcode 001, rs=8'h05, rt=8'h03.
  - `req_ready_o`=2'b01 the same cycle.
  - One cycle later: `rsp_valid_o`=1, `rsp_result_o`=8'h08, `rsp_id_o`=0.
  - `cb_o` stays 0.
- Contention: both requesters continuously valid with `rsp_ready_i`=1 → grants go 0,1,0,1. Each response id matches its grant, and a response completes every 2 cycles.
- Compare:
  - req1 sends opcode 111, rs=rt=8'h2A (with ALU model `alu_zero_i`=1) → `cb_o`=1, `rsp_result_o`=8'h00, id=1.
  - A following opcode 001 leaves `cb_o`=1.
- Backpressure:
  - Hold `rsp_ready_i`=0 for 5 cycles in RESP → response fields stable, `req_ready_o`=0 throughout.
  - Raise `rsp_ready_i` with req0 valid → same-cycle accept, next response 1 cycle later.
- Subtract/abs: opcode 100 with rs=8'h03, rt=8'h05 → result 8'hFE. Opcode 110 with rs=8'h80 → result 8'h80 (wrap), CB unchanged.
